// File: rtl/duck_hunt_pkg.sv
// Shared constants and state encoding for the duck-hunt sprite engine.
package duck_hunt_pkg;

    localparam int SCREEN_X_MAX  = 159;
    localparam int SCREEN_Y_MAX  = 119;
    localparam int DEF_SPR_W     = 8;
    localparam int DEF_SPR_H     = 8;
    localparam int DEF_BG_COLOUR = 0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ERASE_SEL  = 3'd1,
        ST_ERASE_SCAN = 3'd2,
        ST_DRAW_SEL   = 3'd3,
        ST_DRAW_SCAN  = 3'd4,
        ST_FINISH     = 3'd5
    } plot_state_e;

    // Counter width that stays legal for a range of size 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major col/row walker over one SPR_W x SPR_H mask, shared by erase and draw.
module sprite_scan_counter
    import duck_hunt_pkg::*;
#(
    parameter int SPR_W = DEF_SPR_W,
    parameter int SPR_H = DEF_SPR_H,
    localparam int CW   = cnt_w(SPR_W),
    localparam int RW   = cnt_w(SPR_H)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          clear_i,
    input  logic          en_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          last_o
);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          col_end;
    logic          row_end;

    assign col_end = (col_q == CW'(SPR_W - 1));
    assign row_end = (row_q == RW'(SPR_H - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col_q <= '0;
            row_q <= '0;
        end else if (clear_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (en_i) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= row_end ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = col_end && row_end;

endmodule

// File: rtl/sprite_plotter.sv
// Multi-sprite erase/redraw engine: erases every previously drawn sprite, then
// draws every enabled sprite, one clipped pixel per cycle to the VGA plot port.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start; snapshots inputs on start
// ERASE_SEL  | pick sprite idx; scan it if it was drawn last pass
// ERASE_SCAN | walk old box of sprite idx, plotting BG colour
// DRAW_SEL   | pick sprite idx; scan it if enabled in the snapshot
// DRAW_SCAN  | walk new box of sprite idx, plotting sprite colour
// FINISH     | done pulse; new positions become the erase targets
module sprite_plotter
    import duck_hunt_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = DEF_SPR_W,
    parameter int SPR_H       = DEF_SPR_H,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int X_MAX       = SCREEN_X_MAX,
    parameter int Y_MAX       = SCREEN_Y_MAX,
    parameter int COLOUR_W    = 3,
    parameter int BG_COLOUR   = DEF_BG_COLOUR
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            start,
    input  logic [NUM_SPRITES-1:0]          sprite_en,
    input  logic [NUM_SPRITES*X_W-1:0]      pos_x,
    input  logic [NUM_SPRITES*Y_W-1:0]      pos_y,
    input  logic [NUM_SPRITES*COLOUR_W-1:0] sprite_colour,
    input  logic [SPR_W*SPR_H-1:0]          mask,
    output logic [X_W-1:0]                  plot_x,
    output logic [Y_W-1:0]                  plot_y,
    output logic [COLOUR_W-1:0]             plot_colour,
    output logic                            plot,
    output logic                            busy,
    output logic                            done
);

    localparam int IW = cnt_w(NUM_SPRITES);
    localparam int CW = cnt_w(SPR_W);
    localparam int RW = cnt_w(SPR_H);
    localparam int MW = cnt_w(SPR_W * SPR_H);

    plot_state_e                state_q;
    logic [IW-1:0]              idx_q;
    logic [NUM_SPRITES-1:0]     new_en_q;
    logic [NUM_SPRITES-1:0]     prev_valid_q;
    logic [X_W-1:0]             new_x_q    [NUM_SPRITES];
    logic [Y_W-1:0]             new_y_q    [NUM_SPRITES];
    logic [COLOUR_W-1:0]        new_col_q  [NUM_SPRITES];
    logic [X_W-1:0]             prev_x_q   [NUM_SPRITES];
    logic [Y_W-1:0]             prev_y_q   [NUM_SPRITES];

    logic                       idx_last;
    logic                       scan_clear;
    logic                       scan_en;
    logic                       scan_last;
    logic [CW-1:0]              col;
    logic [RW-1:0]              row;

    logic                       in_erase;
    logic                       in_draw;
    logic [X_W-1:0]             cur_x;
    logic [Y_W-1:0]             cur_y;
    logic [X_W:0]               sum_x;
    logic [Y_W:0]               sum_y;
    logic [MW-1:0]              bit_idx;

    assign idx_last   = (idx_q == IW'(NUM_SPRITES - 1));
    assign in_erase   = (state_q == ST_ERASE_SCAN);
    assign in_draw    = (state_q == ST_DRAW_SCAN);
    assign scan_clear = (state_q == ST_ERASE_SEL) || (state_q == ST_DRAW_SEL);
    assign scan_en    = in_erase || in_draw;

    sprite_scan_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_scan (
        .clock   (clock),
        .resetn  (resetn),
        .clear_i (scan_clear),
        .en_i    (scan_en),
        .col_o   (col),
        .row_o   (row),
        .last_o  (scan_last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            new_en_q     <= '0;
            prev_valid_q <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                new_x_q[i]   <= '0;
                new_y_q[i]   <= '0;
                new_col_q[i] <= '0;
                prev_x_q[i]  <= '0;
                prev_y_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        new_en_q <= sprite_en;
                        for (int i = 0; i < NUM_SPRITES; i++) begin
                            new_x_q[i]   <= pos_x[i*X_W +: X_W];
                            new_y_q[i]   <= pos_y[i*Y_W +: Y_W];
                            new_col_q[i] <= sprite_colour[i*COLOUR_W +: COLOUR_W];
                        end
                        idx_q   <= '0;
                        state_q <= ST_ERASE_SEL;
                    end
                end
                ST_ERASE_SEL: begin
                    if (prev_valid_q[idx_q]) begin
                        state_q <= ST_ERASE_SCAN;
                    end else if (idx_last) begin
                        idx_q   <= '0;
                        state_q <= ST_DRAW_SEL;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_ERASE_SCAN: begin
                    if (scan_last) begin
                        if (idx_last) begin
                            idx_q   <= '0;
                            state_q <= ST_DRAW_SEL;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_ERASE_SEL;
                        end
                    end
                end
                ST_DRAW_SEL: begin
                    if (new_en_q[idx_q]) begin
                        state_q <= ST_DRAW_SCAN;
                    end else if (idx_last) begin
                        state_q <= ST_FINISH;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DRAW_SCAN: begin
                    if (scan_last) begin
                        if (idx_last) begin
                            state_q <= ST_FINISH;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_DRAW_SEL;
                        end
                    end
                end
                ST_FINISH: begin
                    for (int i = 0; i < NUM_SPRITES; i++) begin
                        prev_x_q[i] <= new_x_q[i];
                        prev_y_q[i] <= new_y_q[i];
                    end
                    prev_valid_q <= new_en_q;
                    idx_q        <= '0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cur_x = in_erase ? prev_x_q[idx_q] : new_x_q[idx_q];
    assign cur_y = in_erase ? prev_y_q[idx_q] : new_y_q[idx_q];

    // One extra bit so a box hanging off the right/bottom edge clips instead of wrapping.
    assign sum_x   = {1'b0, cur_x} + (X_W+1)'(col);
    assign sum_y   = {1'b0, cur_y} + (Y_W+1)'(row);
    assign bit_idx = MW'(row) * MW'(SPR_W) + MW'(col);

    assign plot = scan_en && mask[bit_idx]
                  && (sum_x <= (X_W+1)'(X_MAX))
                  && (sum_y <= (Y_W+1)'(Y_MAX));

    assign plot_x      = scan_en ? sum_x[X_W-1:0] : '0;
    assign plot_y      = scan_en ? sum_y[Y_W-1:0] : '0;
    assign plot_colour = in_erase ? COLOUR_W'(BG_COLOUR)
                       : in_draw  ? new_col_q[idx_q]
                       : '0;

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FINISH);

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: per-pass plot capture against hand-computed pixels.
module tb_sprite_plotter;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [3:0]  sprite_en;
    logic [31:0] pos_x;
    logic [27:0] pos_y;
    logic [11:0] sprite_colour;
    logic [63:0] mask;
    logic [7:0]  plot_x;
    logic [6:0]  plot_y;
    logic [2:0]  plot_colour;
    logic        plot;
    logic        busy;
    logic        done;

    int checks = 0;
    int passed = 0;

    int qx[$];
    int qy[$];
    int qc[$];
    int cyc;
    int done_cnt;

    sprite_plotter dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .sprite_en     (sprite_en),
        .pos_x         (pos_x),
        .pos_y         (pos_y),
        .sprite_colour (sprite_colour),
        .mask          (mask),
        .plot_x        (plot_x),
        .plot_y        (plot_y),
        .plot_colour   (plot_colour),
        .plot          (plot),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_sprite(input int i, input int x, input int y, input int c);
        pos_x[i*8 +: 8]         = 8'(x);
        pos_y[i*7 +: 7]         = 7'(y);
        sprite_colour[i*3 +: 3] = 3'(c);
    endtask

    // Issues one start edge, then records every plotted pixel until busy falls.
    task automatic run_pass(input bit hold);
        qx.delete(); qy.delete(); qc.delete();
        cyc = 0;
        done_cnt = 0;
        start = 1'b1;
        @(posedge clock);
        forever begin
            @(negedge clock);
            if (!hold) start = 1'b0;
            if (!busy) break;
            cyc++;
            if (plot) begin
                qx.push_back(int'(plot_x));
                qy.push_back(int'(plot_y));
                qc.push_back(int'(plot_colour));
            end
            if (done) done_cnt++;
            if (cyc > 2000) break;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        start = 1'b0;
        sprite_en = '0;
        pos_x = '0;
        pos_y = '0;
        sprite_colour = '0;
        mask = '0;
        #1;
        checks++; if ({plot, busy, done} !== 3'b000) $display("FAIL reset_ctrl: plot/busy/done=%b want 000", {plot, busy, done}); else passed++;
        checks++; if ({plot_x, plot_y, plot_colour} !== 18'd0) $display("FAIL reset_pixel: x=%0d y=%0d c=%0d want 0", plot_x, plot_y, plot_colour); else passed++;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_first_draw;
        int bad;
        sprite_en = 4'b0001;
        set_sprite(0, 10, 20, 5);
        set_sprite(1, 70, 70, 1);
        set_sprite(2, 80, 80, 6);
        set_sprite(3, 90, 90, 3);
        mask = {64{1'b1}};
        run_pass(1'b0);
        checks++; if (cyc !== 73) $display("FAIL first_cycles: got %0d want 73", cyc); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL first_done: got %0d want 1", done_cnt); else passed++;
        checks++; if (qx.size() !== 64) $display("FAIL first_plots: got %0d want 64", qx.size()); else passed++;
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (qx[i] !== 10 + i % 8 || qy[i] !== 20 + i / 8 || qc[i] !== 5) bad++;
        checks++; if (bad !== 0) $display("FAIL first_pixels: %0d wrong pixels want 0", bad); else passed++;
    endtask

    task automatic test_move;
        int bad;
        set_sprite(0, 11, 20, 5);
        run_pass(1'b0);
        checks++; if (cyc !== 137) $display("FAIL move_cycles: got %0d want 137", cyc); else passed++;
        checks++; if (qx.size() !== 128) $display("FAIL move_plots: got %0d want 128", qx.size()); else passed++;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (qx[i] !== 10 + i % 8 || qy[i] !== 20 + i / 8 || qc[i] !== 0) bad++;
            if (qx[64+i] !== 11 + i % 8 || qy[64+i] !== 20 + i / 8 || qc[64+i] !== 5) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL move_pixels: %0d wrong pixels want 0", bad); else passed++;
    endtask

    task automatic test_clip;
        int bad;
        set_sprite(0, 156, 117, 5);
        run_pass(1'b0);
        checks++; if (cyc !== 137) $display("FAIL clip_cycles: got %0d want 137", cyc); else passed++;
        checks++; if (qx.size() !== 76) $display("FAIL clip_plots: got %0d want 76 (64 erase + 12 draw)", qx.size()); else passed++;
        bad = 0;
        for (int i = 0; i < 12; i++)
            if (qx[64+i] !== 156 + i % 4 || qy[64+i] !== 117 + i / 4 || qc[64+i] !== 5) bad++;
        checks++; if (bad !== 0) $display("FAIL clip_pixels: %0d wrong pixels want 0", bad); else passed++;
    endtask

    task automatic test_single_bit;
        set_sprite(0, 0, 0, 5);
        mask = 64'd1 << 9;
        run_pass(1'b0);
        checks++; if (cyc !== 137) $display("FAIL bit9_cycles: got %0d want 137", cyc); else passed++;
        checks++; if (qx.size() !== 2) $display("FAIL bit9_plots: got %0d want 2", qx.size()); else passed++;
        checks++; if ({qx[0], qy[0], qc[0]} !== {32'd157, 32'd118, 32'd0}) $display("FAIL bit9_erase: got (%0d,%0d,%0d) want (157,118,0)", qx[0], qy[0], qc[0]); else passed++;
        checks++; if ({qx[1], qy[1], qc[1]} !== {32'd1, 32'd1, 32'd5}) $display("FAIL bit9_draw: got (%0d,%0d,%0d) want (1,1,5)", qx[1], qy[1], qc[1]); else passed++;
    endtask

    task automatic test_corner;
        int bad;
        set_sprite(0, 159, 119, 5);
        mask = {64{1'b1}};
        run_pass(1'b0);
        checks++; if (qx.size() !== 65) $display("FAIL corner_plots: got %0d want 65", qx.size()); else passed++;
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (qx[i] !== i % 8 || qy[i] !== i / 8 || qc[i] !== 0) bad++;
        checks++; if (bad !== 0) $display("FAIL corner_erase: %0d wrong pixels want 0", bad); else passed++;
        checks++; if ({qx[64], qy[64], qc[64]} !== {32'd159, 32'd119, 32'd5}) $display("FAIL corner_draw: got (%0d,%0d,%0d) want (159,119,5)", qx[64], qy[64], qc[64]); else passed++;
    endtask

    task automatic test_multi;
        int ex[5] = '{159, 30, 37, 100, 107};
        int ey[5] = '{119, 40, 47, 50, 57};
        int ec[5] = '{0, 2, 2, 7, 7};
        int bad;
        sprite_en = 4'b1010;
        set_sprite(1, 30, 40, 2);
        set_sprite(3, 100, 50, 7);
        mask = (64'd1 << 63) | 64'd1;
        run_pass(1'b0);
        checks++; if (cyc !== 201) $display("FAIL multi_cycles: got %0d want 201", cyc); else passed++;
        checks++; if (qx.size() !== 5) $display("FAIL multi_plots: got %0d want 5", qx.size()); else passed++;
        bad = 0;
        for (int i = 0; i < 5; i++)
            if (qx[i] !== ex[i] || qy[i] !== ey[i] || qc[i] !== ec[i]) bad++;
        checks++; if (bad !== 0) $display("FAIL multi_pixels: %0d wrong pixels want 0", bad); else passed++;
    endtask

    task automatic test_start_held;
        int ex[8] = '{30, 37, 100, 107, 30, 37, 100, 107};
        int ey[8] = '{40, 47, 50, 57, 40, 47, 50, 57};
        int ec[8] = '{0, 0, 0, 0, 2, 2, 7, 7};
        int bad;
        int idle_busy;
        run_pass(1'b1);
        start = 1'b0;
        checks++; if (cyc !== 265) $display("FAIL held_cycles: got %0d want 265", cyc); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL held_done: got %0d want 1", done_cnt); else passed++;
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (qx[i] !== ex[i] || qy[i] !== ey[i] || qc[i] !== ec[i]) bad++;
        checks++; if (bad !== 0 || qx.size() !== 8) $display("FAIL held_pixels: %0d wrong of %0d plots want 0 of 8", bad, qx.size()); else passed++;
        idle_busy = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (busy) idle_busy++;
        end
        checks++; if (idle_busy !== 0) $display("FAIL held_requeue: busy for %0d cycles want 0", idle_busy); else passed++;
    endtask

    task automatic test_reset_mid;
        int n;
        int bad;
        sprite_en = 4'b0001;
        set_sprite(0, 50, 60, 4);
        mask = {64{1'b1}};
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(plot && plot_colour == 3'd4) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        checks++; if (n >= 1000) $display("FAIL rst_reach_draw: timed out after %0d cycles want draw plot", n); else passed++;
        #2 resetn = 1'b0;
        #1;
        checks++; if ({plot, busy, done} !== 3'b000) $display("FAIL rst_async: plot/busy/done=%b want 000", {plot, busy, done}); else passed++;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        run_pass(1'b0);
        checks++; if (cyc !== 73) $display("FAIL rst_cycles: got %0d want 73", cyc); else passed++;
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (qx[i] !== 50 + i % 8 || qy[i] !== 60 + i / 8 || qc[i] !== 4) bad++;
        checks++; if (bad !== 0 || qx.size() !== 64) $display("FAIL rst_pixels: %0d wrong of %0d plots want 0 of 64", bad, qx.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_move();
        test_clip();
        test_single_bit();
        test_corner();
        test_multi();
        test_start_held();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
